// File: rtl/mc14500b_sequencer.sv
// Program sequencer for an MC14500B ICU: holds the program, fetches one word
// per cycle, and handles JMP/RTN via a small return stack and FLGF as halt.
module mc14500b_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                prog_we,
    input  logic [ADDR_W-1:0]   prog_waddr,
    input  logic [4+ADDR_W-1:0] prog_wdata,
    input  logic                jmp,
    input  logic                rtn,
    input  logic                flgf,
    output logic [3:0]          instr,
    output logic [ADDR_W-1:0]   operand,
    output logic [ADDR_W-1:0]   pc,
    output logic                running,
    output logic                stack_err
);

    localparam int SP_W   = $clog2(DEPTH + 1);
    localparam int WORD_W = 4 + ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   pc_r, pc_s;
    logic [SP_W-1:0]     sp_r, sp_s;
    logic [3:0]          instr_r, instr_s;
    logic [ADDR_W-1:0]   operand_r, operand_s;
    logic                running_r, running_s;
    logic                stack_err_r, stack_err_s;
    logic                push_s;
    logic [WORD_W-1:0]   fetch_s;
    logic [ADDR_W-1:0]   pop_pc_s;

    // Stack is sized to a power of two so sp indexes it without width mismatch;
    // entries at and above DEPTH are never written.
    logic [WORD_W-1:0]   mem_r   [2**ADDR_W];
    logic [ADDR_W-1:0]   stack_r [2**SP_W];

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] cur);
        return cur + ADDR_W'(1);
    endfunction

    assign fetch_s  = mem_r[pc_r];
    assign pop_pc_s = stack_r[sp_r - SP_W'(1)];

    // Program memory: loadable only while the sequencer is not running; no reset.
    always_ff @(posedge clk) begin
        if (prog_we && (state_r != ST_RUN)) begin
            mem_r[prog_waddr] <= prog_wdata;
        end
    end

    // Return-address stack storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            stack_r[sp_r] <= pc_r;
        end
    end

    // Next-state and next-output logic; flag priority is flgf > jmp > rtn.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        sp_s        = sp_r;
        instr_s     = 4'h0;
        operand_s   = '0;
        stack_err_s = stack_err_r;
        push_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_s     = ST_RUN;
                    pc_s        = '0;
                    sp_s        = '0;
                    stack_err_s = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                if (flgf) begin
                    state_s = ST_HALT;
                end else if (jmp) begin
                    if (sp_r == SP_W'(DEPTH)) begin
                        stack_err_s = 1'b1;
                        state_s     = ST_HALT;
                    end else begin
                        push_s = 1'b1;
                        sp_s   = sp_r + SP_W'(1);
                        pc_s   = operand_r;
                    end
                end else if (rtn) begin
                    if (sp_r == SP_W'(0)) begin
                        stack_err_s = 1'b1;
                        state_s     = ST_HALT;
                    end else begin
                        sp_s = sp_r - SP_W'(1);
                        pc_s = pop_pc_s;
                    end
                end else begin
                    instr_s   = fetch_s[WORD_W-1:ADDR_W];
                    operand_s = fetch_s[ADDR_W-1:0];
                    pc_s      = next_pc(pc_r);
                end
            end
            default: begin
                state_s = ST_IDLE;
                pc_s    = '0;
                sp_s    = '0;
            end
        endcase
        running_s = (state_s == ST_RUN);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            pc_r        <= '0;
            sp_r        <= '0;
            instr_r     <= 4'h0;
            operand_r   <= '0;
            running_r   <= 1'b0;
            stack_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            sp_r        <= sp_s;
            instr_r     <= instr_s;
            operand_r   <= operand_s;
            running_r   <= running_s;
            stack_err_r <= stack_err_s;
        end
    end

    assign instr     = instr_r;
    assign operand   = operand_r;
    assign pc        = pc_r;
    assign running   = running_r;
    assign stack_err = stack_err_r;

endmodule

// File: tb/tb_mc14500b_sequencer.sv
// Directed bench for mc14500b_sequencer: fetch, JMP/RTN, stack errors, wrap, reset.
module tb_mc14500b_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_waddr = 8'h00;
    logic [11:0] prog_wdata = 12'h000;
    logic        jmp = 1'b0;
    logic        rtn = 1'b0;
    logic        flgf = 1'b0;
    logic [3:0]  instr;
    logic [7:0]  operand;
    logic [7:0]  pc;
    logic        running;
    logic        stack_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mc14500b_sequencer #(.ADDR_W(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .prog_we    (prog_we),
        .prog_waddr (prog_waddr),
        .prog_wdata (prog_wdata),
        .jmp        (jmp),
        .rtn        (rtn),
        .flgf       (flgf),
        .instr      (instr),
        .operand    (operand),
        .pc         (pc),
        .running    (running),
        .stack_err  (stack_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [11:0] d);
        prog_waddr = a;
        prog_wdata = d;
        prog_we    = 1'b1;
        tick();
        prog_we    = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({running, stack_err, instr, operand, pc} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected %h", {running, stack_err, instr, operand, pc}, 22'd0);
        end
        n_cmp++;
        if (dut.sp_r !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_sp: got %0d expected 0", dut.sp_r);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({running, pc} !== 9'd0) begin
            n_bad++;
            $display("FAIL idle_hold: got %h expected %h", {running, pc}, 9'd0);
        end
    endtask

    task automatic test_fetch();
        logic [19:0] exp_f [4];
        exp_f = '{20'h10301, 20'h20402, 20'h80503, 20'h90604};
        load(8'd0, 12'h103);
        load(8'd1, 12'h204);
        load(8'd2, 12'h805);
        load(8'd3, 12'h906);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({running, instr, operand, pc} !== {1'b1, 4'h0, 8'h00, 8'h00}) begin
            n_bad++;
            $display("FAIL start_run: got %h expected %h", {running, instr, operand, pc}, {1'b1, 4'h0, 8'h00, 8'h00});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({instr, operand, pc} !== exp_f[i]) begin
                n_bad++;
                $display("FAIL fetch%0d: got %h expected %h", i, {instr, operand, pc}, exp_f[i]);
            end
        end
        flgf = 1'b1;
        tick();
        flgf = 1'b0;
        n_cmp++;
        if ({running, instr, operand, pc} !== {1'b0, 4'h0, 8'h00, 8'h04}) begin
            n_bad++;
            $display("FAIL flgf_halt: got %h expected %h", {running, instr, operand, pc}, {1'b0, 4'h0, 8'h00, 8'h04});
        end
        jmp = 1'b1;
        rtn = 1'b1;
        tick();
        tick();
        jmp = 1'b0;
        rtn = 1'b0;
        n_cmp++;
        if ({running, stack_err, pc, dut.sp_r} !== {1'b0, 1'b0, 8'h04, 3'd0}) begin
            n_bad++;
            $display("FAIL halt_ignores_flags: got %h expected %h", {running, stack_err, pc, dut.sp_r}, {1'b0, 1'b0, 8'h04, 3'd0});
        end
    endtask

    task automatic test_jmp_rtn();
        load(8'd2, 12'hC0A);
        load(8'd10, 12'hD00);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        n_cmp++;
        if ({instr, operand, pc} !== 20'hC0A03) begin
            n_bad++;
            $display("FAIL jmp_word: got %h expected %h", {instr, operand, pc}, 20'hC0A03);
        end
        jmp = 1'b1;
        tick();
        jmp = 1'b0;
        n_cmp++;
        if ({instr, operand, pc, dut.sp_r} !== {20'h0000A, 3'd1}) begin
            n_bad++;
            $display("FAIL jmp_bubble: got %h expected %h", {instr, operand, pc, dut.sp_r}, {20'h0000A, 3'd1});
        end
        tick();
        n_cmp++;
        if ({instr, operand, pc} !== 20'hD000B) begin
            n_bad++;
            $display("FAIL jmp_target: got %h expected %h", {instr, operand, pc}, 20'hD000B);
        end
        rtn = 1'b1;
        tick();
        rtn = 1'b0;
        n_cmp++;
        if ({instr, operand, pc, dut.sp_r} !== {20'h00003, 3'd0}) begin
            n_bad++;
            $display("FAIL rtn_bubble: got %h expected %h", {instr, operand, pc, dut.sp_r}, {20'h00003, 3'd0});
        end
        tick();
        n_cmp++;
        if ({instr, operand, pc} !== 20'h90604) begin
            n_bad++;
            $display("FAIL rtn_target: got %h expected %h", {instr, operand, pc}, 20'h90604);
        end
    endtask

    task automatic test_underflow();
        rtn = 1'b1;
        tick();
        rtn = 1'b0;
        n_cmp++;
        if ({stack_err, running, instr, operand, pc} !== {1'b1, 1'b0, 4'h0, 8'h00, 8'h04}) begin
            n_bad++;
            $display("FAIL underflow: got %h expected %h", {stack_err, running, instr, operand, pc}, {1'b1, 1'b0, 4'h0, 8'h00, 8'h04});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({stack_err, running, pc} !== {1'b0, 1'b1, 8'h00}) begin
            n_bad++;
            $display("FAIL restart: got %h expected %h", {stack_err, running, pc}, {1'b0, 1'b1, 8'h00});
        end
        tick();
        n_cmp++;
        if ({instr, operand, pc} !== 20'h10301) begin
            n_bad++;
            $display("FAIL restart_fetch: got %h expected %h", {instr, operand, pc}, 20'h10301);
        end
        flgf = 1'b1;
        tick();
        flgf = 1'b0;
    endtask

    task automatic test_overflow();
        load(8'd0, 12'hC14);
        load(8'd20, 12'hC1E);
        load(8'd30, 12'hC28);
        load(8'd40, 12'hC32);
        load(8'd50, 12'hC3C);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_cmp++;
        if ({instr, operand, pc} !== 20'hC1401) begin
            n_bad++;
            $display("FAIL nest_first: got %h expected %h", {instr, operand, pc}, 20'hC1401);
        end
        for (int k = 0; k < 4; k++) begin
            jmp = 1'b1;
            tick();
            jmp = 1'b0;
            n_cmp++;
            if ({instr, operand, pc, dut.sp_r} !== {12'h000, 8'(20 + 10 * k), 3'(k + 1)}) begin
                n_bad++;
                $display("FAIL nest_jmp%0d: got %h expected %h", k, {instr, operand, pc, dut.sp_r}, {12'h000, 8'(20 + 10 * k), 3'(k + 1)});
            end
            tick();
            n_cmp++;
            if ({instr, operand, pc} !== {4'hC, 8'(30 + 10 * k), 8'(21 + 10 * k)}) begin
                n_bad++;
                $display("FAIL nest_fetch%0d: got %h expected %h", k, {instr, operand, pc}, {4'hC, 8'(30 + 10 * k), 8'(21 + 10 * k)});
            end
        end
        jmp = 1'b1;
        tick();
        jmp = 1'b0;
        n_cmp++;
        if ({stack_err, running, instr, operand, pc, dut.sp_r} !== {1'b1, 1'b0, 4'h0, 8'h00, 8'd51, 3'd4}) begin
            n_bad++;
            $display("FAIL overflow: got %h expected %h", {stack_err, running, instr, operand, pc, dut.sp_r}, {1'b1, 1'b0, 4'h0, 8'h00, 8'd51, 3'd4});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        flgf = 1'b1;
        jmp  = 1'b1;
        tick();
        flgf = 1'b0;
        jmp  = 1'b0;
        n_cmp++;
        if ({stack_err, running, instr, operand, pc, dut.sp_r} !== {1'b0, 1'b0, 4'h0, 8'h00, 8'h01, 3'd0}) begin
            n_bad++;
            $display("FAIL flgf_over_jmp: got %h expected %h", {stack_err, running, instr, operand, pc, dut.sp_r}, {1'b0, 1'b0, 4'h0, 8'h00, 8'h01, 3'd0});
        end
    endtask

    task automatic test_wrap_reset();
        load(8'd0, 12'hCFE);
        load(8'd254, 12'h311);
        load(8'd255, 12'h422);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        jmp = 1'b1;
        tick();
        jmp = 1'b0;
        n_cmp++;
        if ({instr, operand, pc} !== 20'h000FE) begin
            n_bad++;
            $display("FAIL wrap_jmp: got %h expected %h", {instr, operand, pc}, 20'h000FE);
        end
        start      = 1'b1;
        prog_we    = 1'b1;
        prog_waddr = 8'h00;
        prog_wdata = 12'h555;
        tick();
        start   = 1'b0;
        prog_we = 1'b0;
        n_cmp++;
        if ({running, instr, operand, pc} !== {1'b1, 20'h311FF}) begin
            n_bad++;
            $display("FAIL wrap_254: got %h expected %h", {running, instr, operand, pc}, {1'b1, 20'h311FF});
        end
        tick();
        n_cmp++;
        if ({instr, operand, pc} !== 20'h42200) begin
            n_bad++;
            $display("FAIL wrap_255: got %h expected %h", {instr, operand, pc}, 20'h42200);
        end
        tick();
        n_cmp++;
        if ({instr, operand, pc} !== 20'hCFE01) begin
            n_bad++;
            $display("FAIL run_write_ignored: got %h expected %h", {instr, operand, pc}, 20'hCFE01);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({running, stack_err, instr, operand, pc, dut.sp_r} !== 25'd0) begin
            n_bad++;
            $display("FAIL async_reset: got %h expected %h", {running, stack_err, instr, operand, pc, dut.sp_r}, 25'd0);
        end
        rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({running, instr, operand, pc} !== 21'd0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got %h expected %h", {running, instr, operand, pc}, 21'd0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_cmp++;
        if ({instr, operand, pc} !== 20'hCFE01) begin
            n_bad++;
            $display("FAIL mem_retained: got %h expected %h", {instr, operand, pc}, 20'hCFE01);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_jmp_rtn();
        test_underflow();
        test_overflow();
        test_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
